// File: rtl/scan_mux_reg_pkg.sv
// ---------------------------------------------------------------------------
// scan_mux_pkg
// Shared types and constants for the scan_mux_reg block.
//   state_t      : controller state (idle / direct select / auto-scan)
//   MODE_DIRECT  : mode input value selecting direct (external) channel select
//   MODE_SCAN    : mode input value selecting round-robin auto-scan
//   next_state() : state chosen for the coming edge from en/mode
// ---------------------------------------------------------------------------
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // The state is a pure function of the current en/mode inputs; a mode
  // change made while disabled is therefore picked up when en returns.
  function automatic state_t next_state(input logic en, input logic mode);
    if (!en) begin
      return ST_IDLE;
    end
    return (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
  endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// ---------------------------------------------------------------------------
// scan_mux_reg_if
// Groups the data/control bus of scan_mux_reg.
//   en, mode, sel, din           : driven by the source side (master)
//   dout, dout_valid, cur_ch,
//   wrap                         : driven by the multiplexer (slave)
// Parameters W (data width) and N (channel count) must match the
// scan_mux_reg instance the interface is bound to.
// ---------------------------------------------------------------------------
interface scan_mux_reg_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SELW = $clog2(N);

  logic              en;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*W-1:0]    din;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic [SELW-1:0]   cur_ch;
  logic              wrap;

  modport master (
    output en, mode, sel, din,
    input  dout, dout_valid, cur_ch, wrap
  );

  modport slave (
    input  en, mode, sel, din,
    output dout, dout_valid, cur_ch, wrap
  );

endinterface

// File: rtl/scan_mux_reg_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Counts the cycles the current scan channel has been on the output.
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   inc  : count this cycle as one dwell cycle
//   clr  : restart the count from 0 (this cycle is cycle 0 if inc is set)
//   last : the cycle being counted now is the final one (count == DWELL-1)
// ---------------------------------------------------------------------------
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic last
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] base;

  // 'last' is evaluated against the count this cycle actually uses, so a
  // clear together with inc treats the current cycle as dwell cycle 0.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    base  = clr ? '0 : cnt_q;
    last  = (base == LAST_VAL);
    cnt_d = base;
    if (inc) begin
      cnt_d = last ? '0 : base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// ---------------------------------------------------------------------------
// scan_mux_reg
// Clocked N-channel, W-bit multiplexer with registered output. In direct
// mode the channel comes from bus.sel; in scan mode channels are visited
// round-robin, each held for DWELL cycles. Data is resampled every cycle.
//   clk              : clock, all state on rising edge
//   rst              : synchronous active-high reset
//   bus.en           : 0 freezes dout/cur_ch and the scan position
//   bus.mode         : MODE_DIRECT / MODE_SCAN
//   bus.sel          : direct-mode channel; also seeds scan on entry
//   bus.din          : flattened inputs, channel k = din[k*W +: W]
//   bus.dout         : registered selected data
//   bus.dout_valid   : dout carries a valid sample taken on the last edge
//   bus.cur_ch       : channel that produced dout
//   bus.wrap         : one-cycle pulse on the first channel-0 sample after
//                      the scan wrapped from channel N-1
// ---------------------------------------------------------------------------
module scan_mux_reg
  import scan_mux_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  scan_mux_reg_if.slave  bus
);

  localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] cur_ch_q, cur_ch_d;
  logic [SELW-1:0] scan_ch_q, scan_ch_d;
  logic            wrap_q, wrap_d;
  // Set when the scan steps from N-1 to 0; the pulse is emitted together
  // with the first channel-0 sample that follows.
  logic            wrap_pend_q, wrap_pend_d;

  logic            sel_ok;
  logic            scan_entry;
  logic [SELW-1:0] base_ch;
  logic [SELW-1:0] rd_ch;
  logic [W-1:0]    rd_data;
  logic            cnt_inc;
  logic            cnt_clr;
  logic            dwell_last;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = next_state(bus.en, bus.mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Channel selection for this edge
  // -------------------------------------------------------------------------
  always_comb begin
    sel_ok     = ({1'b0, bus.sel} < N_EXT);
    // Only a direct->scan transition reseeds the scan; idle->scan resumes.
    scan_entry = (state_q == ST_DIRECT);
    base_ch    = scan_ch_q;
    if (scan_entry) begin
      base_ch = sel_ok ? bus.sel : '0;
    end
    rd_ch = (state_d == ST_SCAN) ? base_ch : bus.sel;
  end

  // N-way select; a channel index >= N matches nothing and reads as 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_ch == SELW'(k)) begin
        rd_data = bus.din[k*W +: W];
      end
    end
  end

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .last (dwell_last)
  );

  // -------------------------------------------------------------------------
  // Output / scan-position next state
  // -------------------------------------------------------------------------
  always_comb begin
    dout_d      = dout_q;
    valid_d     = 1'b0;
    cur_ch_d    = cur_ch_q;
    wrap_d      = 1'b0;
    scan_ch_d   = scan_ch_q;
    wrap_pend_d = wrap_pend_q;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;

    case (state_d)
      ST_DIRECT: begin
        dout_d      = rd_data;
        cur_ch_d    = bus.sel;
        valid_d     = sel_ok;
        cnt_clr     = 1'b1;
        wrap_pend_d = 1'b0;
      end

      ST_SCAN: begin
        cnt_clr     = scan_entry;
        cnt_inc     = 1'b1;
        dout_d      = rd_data;
        cur_ch_d    = base_ch;
        valid_d     = 1'b1;
        wrap_d      = wrap_pend_q && !scan_entry;
        wrap_pend_d = 1'b0;
        scan_ch_d   = base_ch;
        if (dwell_last) begin
          scan_ch_d   = (base_ch == LAST_CH) ? '0 : base_ch + 1'b1;
          wrap_pend_d = (base_ch == LAST_CH);
        end
      end

      default: begin
        // Idle: outputs hold, valid/wrap low, scan position frozen.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      valid_q     <= 1'b0;
      cur_ch_q    <= '0;
      scan_ch_q   <= '0;
      wrap_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      cur_ch_q    <= cur_ch_d;
      scan_ch_q   <= scan_ch_d;
      wrap_q      <= wrap_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_scan_mux_reg
// Directed bench for scan_mux_reg. Three instances:
//   dut_a : W=8, N=4, DWELL=3  (reset, direct, sweep, freeze, mode switch)
//   dut_b : W=8, N=3, DWELL=2  (out-of-range select, non-power-of-two N)
//   dut_c : W=8, N=4, DWELL=1  (channel advances every cycle)
// Channel k carries 0x11*(k+1).
// ---------------------------------------------------------------------------
module tb_scan_mux_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  scan_mux_reg_if #(.W(8), .N(4)) bus_a ();
  scan_mux_reg_if #(.W(8), .N(3)) bus_b ();
  scan_mux_reg_if #(.W(8), .N(4)) bus_c ();

  scan_mux_reg #(.W(8), .N(4), .DWELL(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  scan_mux_reg #(.W(8), .N(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  scan_mux_reg #(.W(8), .N(4), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag,
                           input logic [7:0] d, input logic v,
                           input logic [1:0] c, input logic w,
                           input int ed, input int ev, input int ec, input int ew);
    check({tag, ".dout"},   32'(d), 32'(ed));
    check({tag, ".valid"},  32'(v), 32'(ev));
    check({tag, ".cur_ch"}, 32'(c), 32'(ec));
    check({tag, ".wrap"},   32'(w), 32'(ew));
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int chv(input int k);
    return 'h11 * (k + 1);
  endfunction

  initial begin
    rst = 1'b1;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.sel = '0; bus_a.din = 32'h44332211;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.sel = '0; bus_b.din = 24'h332211;
    bus_c.en = 1'b0; bus_c.mode = 1'b0; bus_c.sel = '0; bus_c.din = 32'h44332211;

    // ---------------- dut_a: reset has priority, then direct select ------
    bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.sel = 2'd2;
    tick();
    check_out("a_rst0", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 0, 0, 0, 0);
    tick();
    check_out("a_rst1", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_out("a_direct2", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);

    // ---------------- scan sweep, DWELL=3, wrap on return to ch0 ---------
    bus_a.sel = 2'd0; bus_a.mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_out($sformatf("a_sweep%0d", i), bus_a.dout, bus_a.dout_valid,
                bus_a.cur_ch, bus_a.wrap, chv((i / 3) % 4), 1, (i / 3) % 4, (i == 12) ? 1 : 0);
    end

    // ---------------- freeze during 2nd cycle of ch1 ---------------------
    bus_a.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("a_freeze%0d", i), bus_a.dout, bus_a.dout_valid,
                bus_a.cur_ch, bus_a.wrap, 'h22, 0, 1, 0);
    end
    bus_a.en = 1'b1;
    tick();
    check_out("a_resume_ch1", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h22, 1, 1, 0);
    tick();
    check_out("a_ch2_s0", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);
    tick();
    check_out("a_ch2_s1", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);

    // en drops on the dwell-expiry edge: nothing advances
    bus_a.en = 1'b0;
    tick();
    check_out("a_freeze_exp", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 0, 2, 0);
    bus_a.en = 1'b1;
    tick();
    check_out("a_ch2_s2", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);
    tick();
    check_out("a_ch3_s0", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h44, 1, 3, 0);

    // ---------------- mode switching -------------------------------------
    bus_a.mode = 1'b0; bus_a.sel = 2'd2;
    tick();
    check_out("a_sw_direct", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);
    bus_a.mode = 1'b1;
    tick();
    check_out("a_sw_t0", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);
    tick();
    check_out("a_sw_t1", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h33, 1, 2, 0);
    bus_a.mode = 1'b0; bus_a.sel = 2'd0;
    tick();
    check_out("a_sw_t2", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h11, 1, 0, 0);

    // din change is resampled on the next edge
    bus_a.din[7:0] = 8'h5a;
    tick();
    check_out("a_din_chg", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 'h5a, 1, 0, 0);
    bus_a.din[7:0] = 8'h11;

    // ---------------- reset mid-scan -------------------------------------
    bus_a.mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out($sformatf("a_pre_rst%0d", i), bus_a.dout, bus_a.dout_valid,
                bus_a.cur_ch, bus_a.wrap, chv(i / 3), 1, i / 3, 0);
    end
    rst = 1'b1;
    tick();
    check_out("a_mid_rst", bus_a.dout, bus_a.dout_valid, bus_a.cur_ch, bus_a.wrap, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("a_post_rst%0d", i), bus_a.dout, bus_a.dout_valid,
                bus_a.cur_ch, bus_a.wrap, chv(i / 3), 1, i / 3, 0);
    end
    bus_a.en = 1'b0;

    // ---------------- dut_b: N=3, out-of-range select --------------------
    rst = 1'b1;
    tick();
    check_out("b_rst", bus_b.dout, bus_b.dout_valid, bus_b.cur_ch, bus_b.wrap, 0, 0, 0, 0);
    rst = 1'b0;
    bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.sel = 2'd3;
    tick();
    check_out("b_sel3", bus_b.dout, bus_b.dout_valid, bus_b.cur_ch, bus_b.wrap, 0, 0, 3, 0);
    bus_b.sel = 2'd1;
    tick();
    check_out("b_sel1", bus_b.dout, bus_b.dout_valid, bus_b.cur_ch, bus_b.wrap, 'h22, 1, 1, 0);
    bus_b.sel = 2'd3;
    tick();
    check_out("b_sel3b", bus_b.dout, bus_b.dout_valid, bus_b.cur_ch, bus_b.wrap, 0, 0, 3, 0);
    bus_b.mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out($sformatf("b_scan%0d", i), bus_b.dout, bus_b.dout_valid,
                bus_b.cur_ch, bus_b.wrap, chv((i / 2) % 3), 1, (i / 2) % 3, (i == 6) ? 1 : 0);
    end
    bus_b.en = 1'b0;

    // ---------------- dut_c: DWELL=1 -------------------------------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_c.en = 1'b1; bus_c.mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_out($sformatf("c_scan%0d", i), bus_c.dout, bus_c.dout_valid,
                bus_c.cur_ch, bus_c.wrap, chv(i % 4), 1, i % 4, (i == 4 || i == 8) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
